// File: rtl/wave_ctrl_pkg.sv
// Shared definitions for the waveform generator controller: FSM encoding,
// config register map and CTRL field positions.
package wave_ctrl_pkg;

    localparam int NUM_WAVES_DEF = 4;
    localparam int DATA_W_DEF    = 16;
    localparam int CNT_W_DEF     = 16;
    localparam int SEL_W         = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_APPLY,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] CFG_ADDR_CTRL      = 2'd0;
    localparam logic [1:0] CFG_ADDR_PRESCALER = 2'd1;
    localparam logic [1:0] CFG_ADDR_AMPLITUDE = 2'd2;
    localparam logic [1:0] CFG_ADDR_BURST     = 2'd3;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_SEL_LO = 1;
    localparam int CTRL_BURST  = 3;

    // Indices with no generator attached fall back to generator 0.
    function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] sel, input int num);
        return (int'(sel) >= num) ? '0 : sel;
    endfunction

endpackage

// File: rtl/wave_period_detect.sv
// Flags a period boundary: the selected sample returns to 0 from a non-zero
// value, or every enabled cycle when the amplitude is 0 (flat waveform).
module wave_period_detect #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] sample,
    input  logic              amp_zero,
    output logic              boundary
);

    logic [DATA_W-1:0] prev_q;
    logic [DATA_W-1:0] prev_d;

    // History is cleared outside RUN so a restarted generator's first 0 is not a boundary.
    always_comb begin
        prev_d = en ? sample : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign boundary = en && (amp_zero || ((sample == '0) && (prev_q != '0)));

endmodule

// File: rtl/wave_gen_controller.sv
// Config register set, run/burst sequencing and output mux for a bank of
// waveform generators; parameter updates in RUN are deferred to a period boundary.
module wave_gen_controller
    import wave_ctrl_pkg::*;
#(
    parameter int NUM_WAVES = NUM_WAVES_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [1:0]                  cfg_addr,
    input  logic [DATA_W-1:0]           cfg_wdata,
    output logic [NUM_WAVES-1:0]        gen_ena,
    output logic [DATA_W-1:0]           gen_prescaler,
    output logic [DATA_W-1:0]           gen_amplitude,
    input  logic [NUM_WAVES*DATA_W-1:0] gen_data,
    output logic [DATA_W-1:0]           wave_out,
    output logic                        wave_valid,
    output logic                        busy,
    output logic                        burst_done
);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d, sh_sel_q, sh_sel_d;
    logic [DATA_W-1:0] presc_q, presc_d, sh_presc_q, sh_presc_d;
    logic [DATA_W-1:0] amp_q, amp_d, sh_amp_q, sh_amp_d;
    logic              pending_q, pending_d, stop_req_q, stop_req_d;
    logic              burst_mode_q, burst_mode_d;
    logic [CNT_W-1:0]  burst_cfg_q, burst_cfg_d, burst_target_q, burst_target_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [DATA_W-1:0] wave_out_q, wave_out_d;
    logic              wave_valid_q, wave_valid_d, burst_done_q, burst_done_d;

    logic              wr, stop_wr, boundary;
    logic [SEL_W-1:0]  wsel;
    logic [DATA_W-1:0] sample;

    assign wr      = cfg_valid && cfg_ready;
    assign wsel    = clamp_sel(cfg_wdata[CTRL_SEL_LO +: SEL_W], NUM_WAVES);
    assign stop_wr = wr && (cfg_addr == CFG_ADDR_CTRL) && !cfg_wdata[CTRL_RUN];
    assign sample  = gen_data[int'(sel_q)*DATA_W +: DATA_W];
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    wave_period_detect #(.DATA_W(DATA_W)) u_detect (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state_q == ST_RUN),
        .sample   (sample),
        .amp_zero (amp_q == '0),
        .boundary (boundary)
    );

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        presc_d        = presc_q;
        amp_d          = amp_q;
        sh_sel_d       = sh_sel_q;
        sh_presc_d     = sh_presc_q;
        sh_amp_d       = sh_amp_q;
        pending_d      = pending_q;
        stop_req_d     = stop_req_q;
        burst_mode_d   = burst_mode_q;
        burst_cfg_d    = burst_cfg_q;
        burst_target_d = burst_target_q;
        cnt_d          = cnt_q;
        wave_out_d     = wave_out_q;
        wave_valid_d   = 1'b0;
        burst_done_d   = 1'b0;

        if (wr && (cfg_addr == CFG_ADDR_BURST)) begin
            burst_cfg_d = CNT_W'(cfg_wdata);
        end

        case (state_q)
            ST_IDLE: begin
                wave_out_d = '0;
                if (wr) begin
                    case (cfg_addr)
                        CFG_ADDR_PRESCALER: presc_d = cfg_wdata;
                        CFG_ADDR_AMPLITUDE: amp_d   = cfg_wdata;
                        CFG_ADDR_CTRL: begin
                            sel_d        = wsel;
                            burst_mode_d = cfg_wdata[CTRL_BURST];
                            if (cfg_wdata[CTRL_RUN]) state_d = ST_START;
                        end
                        default: ;
                    endcase
                end
            end
            ST_START: begin
                cnt_d          = '0;
                stop_req_d     = 1'b0;
                burst_target_d = burst_cfg_q;
                if (burst_mode_q && (burst_cfg_q == '0)) begin
                    burst_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                wave_out_d   = sample;
                wave_valid_d = 1'b1;
                // Shadow starts as a copy of the active set so a single-field write keeps the rest.
                if (wr && !stop_wr && (cfg_addr != CFG_ADDR_BURST)) begin
                    sh_sel_d   = sel_q;
                    sh_presc_d = presc_q;
                    sh_amp_d   = amp_q;
                    pending_d  = 1'b1;
                    case (cfg_addr)
                        CFG_ADDR_PRESCALER: sh_presc_d = cfg_wdata;
                        CFG_ADDR_AMPLITUDE: sh_amp_d   = cfg_wdata;
                        default:            sh_sel_d   = wsel;
                    endcase
                end
                if (stop_wr) stop_req_d = 1'b1;
                if (boundary) begin
                    cnt_d = cnt_inc;
                    if (stop_req_q || stop_wr) begin
                        state_d = ST_DRAIN;
                    end else if (burst_mode_q && (cnt_inc >= burst_target_q)) begin
                        state_d      = ST_DRAIN;
                        burst_done_d = 1'b1;
                    end else if (pending_q) begin
                        state_d = ST_APPLY;
                    end
                end
                if (state_d == ST_DRAIN) begin
                    pending_d    = 1'b0;
                    wave_out_d   = '0;
                    wave_valid_d = 1'b0;
                end else if (state_d == ST_APPLY) begin
                    wave_out_d   = wave_out_q;
                    wave_valid_d = 1'b0;
                end
            end
            ST_APPLY: begin
                sel_d     = sh_sel_q;
                presc_d   = sh_presc_q;
                amp_d     = sh_amp_q;
                pending_d = 1'b0;
                state_d   = ST_RUN;
            end
            ST_DRAIN: begin
                wave_out_d = '0;
                pending_d  = 1'b0;
                stop_req_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            sel_q          <= '0;
            presc_q        <= '0;
            amp_q          <= '0;
            sh_sel_q       <= '0;
            sh_presc_q     <= '0;
            sh_amp_q       <= '0;
            pending_q      <= 1'b0;
            stop_req_q     <= 1'b0;
            burst_mode_q   <= 1'b0;
            burst_cfg_q    <= '0;
            burst_target_q <= '0;
            cnt_q          <= '0;
            wave_out_q     <= '0;
            wave_valid_q   <= 1'b0;
            burst_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            presc_q        <= presc_d;
            amp_q          <= amp_d;
            sh_sel_q       <= sh_sel_d;
            sh_presc_q     <= sh_presc_d;
            sh_amp_q       <= sh_amp_d;
            pending_q      <= pending_d;
            stop_req_q     <= stop_req_d;
            burst_mode_q   <= burst_mode_d;
            burst_cfg_q    <= burst_cfg_d;
            burst_target_q <= burst_target_d;
            cnt_q          <= cnt_d;
            wave_out_q     <= wave_out_d;
            wave_valid_q   <= wave_valid_d;
            burst_done_q   <= burst_done_d;
        end
    end

    always_comb begin
        gen_ena = '0;
        if (state_q == ST_RUN) gen_ena[sel_q] = 1'b1;
    end

    assign cfg_ready     = (state_q == ST_IDLE) || ((state_q == ST_RUN) && !pending_q);
    assign busy          = (state_q != ST_IDLE);
    assign gen_prescaler = presc_q;
    assign gen_amplitude = amp_q;
    assign wave_out      = wave_out_q;
    assign wave_valid    = wave_valid_q;
    assign burst_done    = burst_done_q;

endmodule

// File: tb/tb_wave_gen_controller.sv
// Directed bench: sawtooth generator models feed the controller; expected
// values are hand-derived cycle by cycle.
module tb_wave_gen_controller;

    localparam int NW = 4;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [1:0]       cfg_addr = '0;
    logic [DW-1:0]    cfg_wdata = '0;
    logic [NW-1:0]    gen_ena;
    logic [DW-1:0]    gen_prescaler, gen_amplitude;
    logic [NW*DW-1:0] gen_data;
    logic [DW-1:0]    wave_out;
    logic             wave_valid, busy, burst_done;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] gcnt [NW];

    wave_gen_controller dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .gen_ena(gen_ena),
        .gen_prescaler(gen_prescaler), .gen_amplitude(gen_amplitude), .gen_data(gen_data),
        .wave_out(wave_out), .wave_valid(wave_valid), .busy(busy), .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    // Sawtooth 0..amplitude; generator i tags non-zero samples with i in bits [15:12].
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NW; i++) begin
            if (!rst_n || !gen_ena[i]) gcnt[i] <= '0;
            else if (gcnt[i] >= gen_amplitude) gcnt[i] <= '0;
            else gcnt[i] <= gcnt[i] + 16'd1;
        end
    end

    always_comb begin
        gen_data = '0;
        for (int i = 0; i < NW; i++) begin
            gen_data[i*DW +: DW] = (gcnt[i] == '0) ? '0 : gcnt[i] + 16'(i * 16'h1000);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [DW-1:0] d);
        int n = 0;
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        while (!cfg_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("wr_ready_timeout", 32'(cfg_ready), 1);
        step();
        cfg_valid = 1'b0;
    endtask

    logic [DW-1:0] exp1 [5] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
    logic [DW-1:0] exp2 [7] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0};

    initial begin
        int n;
        int peaks;

        // Reset state
        #12;
        chk("rst_wave_out", 32'(wave_out), 0);
        chk("rst_wave_valid", 32'(wave_valid), 0);
        chk("rst_gen_ena", 32'(gen_ena), 0);
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_burst_done", 32'(burst_done), 0);
        rst_n = 1'b1;
        step();

        // 1: sawtooth amplitude 3
        wr(2'd1, 16'd0);
        wr(2'd2, 16'd3);
        wr(2'd0, 16'h0001);
        chk("t1_start_busy", 32'(busy), 1);
        chk("t1_start_ena", 32'(gen_ena), 0);
        step();
        chk("t1_run_ena", 32'(gen_ena), 32'b0001);
        chk("t1_run_valid0", 32'(wave_valid), 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("t1_wave_out[%0d]", i), 32'(wave_out), 32'(exp1[i]));
            chk($sformatf("t1_valid[%0d]", i), 32'(wave_valid), 1);
        end

        // 2: amplitude update deferred to boundary
        wr(2'd2, 16'd5);
        chk("t2_ready_low", 32'(cfg_ready), 0);
        n = 0;
        while (gen_ena != '0 && n < 20) begin
            step();
            n++;
        end
        chk("t2_cycles_to_apply", 32'(n), 3);
        chk("t2_apply_valid", 32'(wave_valid), 0);
        chk("t2_apply_hold", 32'(wave_out), 3);
        chk("t2_apply_busy", 32'(busy), 1);
        chk("t2_apply_ready", 32'(cfg_ready), 0);
        step();
        chk("t2_rerun_ena", 32'(gen_ena), 32'b0001);
        chk("t2_rerun_ready", 32'(cfg_ready), 1);
        chk("t2_amp_active", 32'(gen_amplitude), 5);
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("t2_wave_out[%0d]", i), 32'(wave_out), 32'(exp2[i]));
        end

        // stop via run=0 at next boundary
        wr(2'd0, 16'h0000);
        n = 0;
        while (gen_ena != '0 && n < 20) begin
            step();
            n++;
        end
        chk("stop_drain_busy", 32'(busy), 1);
        chk("stop_drain_out", 32'(wave_out), 0);
        chk("stop_drain_done", 32'(burst_done), 0);
        step();
        chk("stop_idle_busy", 32'(busy), 0);

        // 3: burst of 2 periods on generator 1, amplitude 2
        wr(2'd2, 16'd2);
        wr(2'd3, 16'd2);
        wr(2'd0, 16'h000B);
        n = 0;
        peaks = 0;
        while (!burst_done && n < 40) begin
            step();
            n++;
            if (wave_valid && wave_out == 16'h1002) peaks++;
        end
        chk("t3_cycles_to_done", 32'(n), 8);
        chk("t3_peaks", 32'(peaks), 2);
        chk("t3_drain_ena", 32'(gen_ena), 0);
        chk("t3_drain_out", 32'(wave_out), 0);
        step();
        chk("t3_idle_busy", 32'(busy), 0);
        chk("t3_done_pulse", 32'(burst_done), 0);
        chk("t3_idle_ready", 32'(cfg_ready), 1);

        // 4: burst count 0
        wr(2'd3, 16'd0);
        wr(2'd0, 16'h0009);
        chk("t4_start_busy", 32'(busy), 1);
        chk("t4_start_ena", 32'(gen_ena), 0);
        step();
        chk("t4_done", 32'(burst_done), 1);
        chk("t4_idle", 32'(busy), 0);
        chk("t4_ena", 32'(gen_ena), 0);
        step();
        chk("t4_done_clear", 32'(burst_done), 0);

        // 5: amplitude 0, stop drains immediately
        wr(2'd2, 16'd0);
        wr(2'd0, 16'h0001);
        step();
        chk("t5_run_ena", 32'(gen_ena), 32'b0001);
        step();
        wr(2'd0, 16'h0000);
        chk("t5_drain_busy", 32'(busy), 1);
        chk("t5_drain_ena", 32'(gen_ena), 0);
        chk("t5_drain_out", 32'(wave_out), 0);
        step();
        chk("t5_idle", 32'(busy), 0);

        // 6: async reset mid-run with pending update
        wr(2'd2, 16'd3);
        wr(2'd0, 16'h0001);
        for (int i = 0; i < 4; i++) step();
        chk("t6_pre_out", 32'(wave_out), 2);
        wr(2'd2, 16'd7);
        chk("t6_pending", 32'(cfg_ready), 0);
        chk("t6_pre_out2", 32'(wave_out), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_out", 32'(wave_out), 0);
        chk("t6_rst_valid", 32'(wave_valid), 0);
        chk("t6_rst_ena", 32'(gen_ena), 0);
        chk("t6_rst_amp", 32'(gen_amplitude), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_ready", 32'(cfg_ready), 1);
        step();
        rst_n = 1'b1;
        step();
        chk("t6_rel_ready", 32'(cfg_ready), 1);
        wr(2'd0, 16'h0001);
        step();
        chk("t6_run_ena", 32'(gen_ena), 32'b0001);
        chk("t6_no_pending", 32'(cfg_ready), 1);
        chk("t6_amp_zero", 32'(gen_amplitude), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
